stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 250000, is the number of consecutive clk cycles a synchronized P level must hold before the debounced level changes.
REQ-002 clk  input  1  system clock; single clock domain for all state.
REQ-003 R  input  1  reset; asynchronous and active-high.
REQ-004 tick  input  1  centisecond strobe, one clk cycle wide, from the clock divider.
REQ-005 P  input  1  raw start/pause pushbutton; asynchronous, bouncing.
REQ-006 sel  input  2  mode: 00 up from 00.00, 01 up from load, 10 down from 99.99, 11 down from load.
REQ-007 load  input  8  preset seconds as BCD: [7:4] tens digit, [3:0] units digit.
REQ-008 cnt_max  input  1  counter datapath currently holds 99.99.
REQ-009 cnt_zero  input  1  counter datapath currently holds 00.00.
REQ-010 cnt_en  output  1  advance the counter by one count this cycle.
REQ-011 cnt_dir  output  1  count direction: 1 = up, 0 = down.
REQ-012 ld_strobe  output  1  counter loads ld_val this cycle.
REQ-013 ld_val  output  16  preset value as four BCD digits, SS.HH.
REQ-014 cstate  output  2  current state code, for debug LEDs.

Function
REQ-015 P shall pass through a 2-flop synchronizer; the debounced level shall change only after the synchronized level differs from it for DB_CYCLES consecutive cycles.
REQ-016 press shall be a 1-cycle internal pulse on each 0->1 transition of the debounced level; releasing the button generates nothing.
REQ-017 States and cstate encodings: IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-018 IDLE: ld_strobe=1 every cycle and cnt_en=0.
REQ-019 IDLE: ld_val and cnt_dir shall track the live sel each cycle.
REQ-020 IDLE transitions: on press, latch sel into mode_q and go to RUN.
REQ-021 RUN, PAUSE and DONE: ld_strobe=0; ld_val and cnt_dir derive from mode_q, so sel changes are ignored.
REQ-022 ld_val for mode 00 shall be 0x0000.
REQ-023 ld_val for mode 10 shall be 0x9999.
REQ-024 ld_val for modes 01/11 shall be {load[7:4], load[3:0], 0x0, 0x0}, with any load nibble greater than 9 clamped to 9.
REQ-025 cnt_dir shall be ~mode[1].
REQ-026 terminal shall be cnt_max when cnt_dir=1, else cnt_zero.
REQ-027 RUN: cnt_en = tick & ~terminal.
REQ-028 RUN transitions: tick & terminal goes to DONE; otherwise press goes to PAUSE.
REQ-029 Simultaneous events: if press, tick and terminal coincide in RUN, DONE shall win.
REQ-030 PAUSE: cnt_en=0; press returns to RUN; ticks are ignored.
REQ-031 DONE: cnt_en=0; press is ignored; only R exits.
REQ-032 Preset at terminal: if the counter already holds the terminal value when RUN is entered (e.g. mode 11, load=00), the first tick shall go to DONE with no count.
REQ-033 cnt_en, ld_strobe, ld_val and cnt_dir shall be combinational from registered state, mode_q and the inputs; cstate shall equal the state register.
REQ-034 Latency: a clean P rise shall change cstate DB_CYCLES+3 clk edges after P is first sampled high.

Reset
REQ-035 R asserted shall immediately force state=IDLE, mode_q=00, synchronizer=0, debounced level=0 and debounce counter=0.
REQ-036 While R is high, outputs shall be: cstate=00, cnt_en=0, ld_strobe=1, cnt_dir=~sel[1], ld_val per live sel.
REQ-037 Reset asserted mid-debounce or mid-RUN shall discard the pending press and the running state; the first press after release counts only if P is then stable for DB_CYCLES.

Structure
REQ-038 The shared package stopwatch_pkg shall hold the state encodings, the mode encodings for sel, and the BCD constants 0x0000 and 0x9999.
REQ-039 The debounce logic (synchronizer, counter, edge pulse) shall be one sub-module, btn_debounce, parameterized by DB_CYCLES and outputting press.
REQ-040 The FSM, mode latch and ld_val mux shall live in stopwatch_ctrl.

Verification (DB_CYCLES=4)
REQ-041 The bench shall cover these directed scenarios:
- Reset, then sel=01, load=0x25 -> cstate=00, ld_strobe=1, ld_val=0x2500, cnt_dir=1.
- P high for 3 cycles, then low -> no press, cstate remains 00.
- P high for 10 cycles -> cstate=01 exactly 7 edges after the first sample; with cnt_max=0, cnt_en asserts on every tick.
- In RUN, mode 10, drive cnt_zero=1 and tick=1 with a concurrent press -> cnt_en=0, next cstate=11; later presses leave cstate=11.
- In RUN, press -> cstate=10 and ticks give cnt_en=0; then change sel to 00 and press -> cstate=01, cnt_dir unchanged (0).
- Assert R mid-RUN, async between clk edges -> cstate=00 and cnt_en=0 before the next edge; ld_strobe=1.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch controller: FSM states, sel modes and BCD constants.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10,
        StDone  = 2'b11
    } sw_state_e;

    localparam logic [1:0] ModeUpZero   = 2'b00;
    localparam logic [1:0] ModeUpLoad   = 2'b01;
    localparam logic [1:0] ModeDownMax  = 2'b10;
    localparam logic [1:0] ModeDownLoad = 2'b11;

    localparam logic [15:0] BcdZero = 16'h0000;
    localparam logic [15:0] BcdMax  = 16'h9999;

    // Saturate an out-of-range BCD nibble to 9.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter and rising-edge press pulse.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int unsigned CntW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);

    logic [1:0]      sync_q, sync_d;
    logic            db_q, db_d;
    logic            db_prev_q;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync_d = {sync_q[0], btn};
        db_d   = db_q;
        cnt_d  = '0;
        // Count consecutive cycles of disagreement; any agreement restarts the count.
        if (sync_q[1] != db_q) begin
            if (cnt_q == CntLast) begin
                db_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= 2'b00;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync_q    <= sync_d;
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q     <= cnt_d;
        end
    end

    assign press = db_q & ~db_prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: start/pause/done sequencing, mode latch and preset-value mux.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 250000
) (
    input  logic        clk,
    input  logic        R,
    input  logic        tick,
    input  logic        P,
    input  logic [1:0]  sel,
    input  logic [7:0]  load,
    input  logic        cnt_max,
    input  logic        cnt_zero,
    output logic        cnt_en,
    output logic        cnt_dir,
    output logic        ld_strobe,
    output logic [15:0] ld_val,
    output logic [1:0]  cstate
);

    sw_state_e  state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [1:0] mode_eff;
    logic       press;
    logic       terminal;

    btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_btn_debounce (
        .clk  (clk),
        .rst  (R),
        .btn  (P),
        .press(press)
    );

    // In IDLE the outputs follow the live selector so the counter preloads continuously.
    assign mode_eff = (state_q == StIdle) ? sel : mode_q;

    always_comb begin
        unique case (mode_eff)
            ModeUpZero:  ld_val = BcdZero;
            ModeDownMax: ld_val = BcdMax;
            default:     ld_val = {bcd_clamp(load[7:4]), bcd_clamp(load[3:0]), 8'h00};
        endcase
    end

    assign cnt_dir   = ~mode_eff[1];
    assign terminal  = cnt_dir ? cnt_max : cnt_zero;
    assign cnt_en    = (state_q == StRun) & tick & ~terminal;
    assign ld_strobe = (state_q == StIdle);
    assign cstate    = state_q;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        unique case (state_q)
            StIdle: begin
                if (press) begin
                    mode_d  = sel;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Reaching the terminal count takes priority over a coincident press.
                if (tick && terminal) begin
                    state_d = StDone;
                end else if (press) begin
                    state_d = StPause;
                end
            end
            StPause: begin
                if (press) begin
                    state_d = StRun;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state_q <= StIdle;
            mode_q  <= ModeUpZero;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios then randomized traffic vs a reference model.
module tb_stopwatch_ctrl;

    localparam int DB = 4;

    logic        clk;
    logic        R;
    logic        tick;
    logic        P;
    logic [1:0]  sel;
    logic [7:0]  load;
    logic        cnt_max;
    logic        cnt_zero;
    logic        cnt_en;
    logic        cnt_dir;
    logic        ld_strobe;
    logic [15:0] ld_val;
    logic [1:0]  cstate;

    stopwatch_ctrl #(
        .DB_CYCLES(DB)
    ) dut (
        .clk      (clk),
        .R        (R),
        .tick     (tick),
        .P        (P),
        .sel      (sel),
        .load     (load),
        .cnt_max  (cnt_max),
        .cnt_zero (cnt_zero),
        .cnt_en   (cnt_en),
        .cnt_dir  (cnt_dir),
        .ld_strobe(ld_strobe),
        .ld_val   (ld_val),
        .cstate   (cstate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Staged stimulus, applied at each falling edge.
    logic       d_R, d_tick, d_P, d_max, d_zero;
    logic [1:0] d_sel;
    logic [7:0] d_load;

    // Reference model: P sample history, stable-run length, debounced level, press flag,
    // and a stopwatch state number 0=idle 1=run 2=pause 3=done.
    bit   p_hist[$];
    bit   m_db;
    int   m_run;
    bit   m_press;
    int   m_state;
    int   m_mode;

    function automatic void model_reset();
        p_hist  = '{0, 0};
        m_db    = 0;
        m_run   = 0;
        m_press = 0;
        m_state = 0;
        m_mode  = 0;
    endfunction

    function automatic int eff_mode();
        return (m_state == 0) ? int'(sel) : m_mode;
    endfunction

    function automatic bit exp_dir();
        return eff_mode() < 2;
    endfunction

    function automatic bit exp_terminal();
        return exp_dir() ? bit'(cnt_max) : bit'(cnt_zero);
    endfunction

    function automatic logic [15:0] exp_ld_val();
        int hi, lo;
        hi = (load[7:4] > 9) ? 9 : int'(load[7:4]);
        lo = (load[3:0] > 9) ? 9 : int'(load[3:0]);
        case (eff_mode())
            0:       return 16'h0000;
            2:       return 16'h9999;
            default: return 16'(hi * 4096 + lo * 256);
        endcase
    endfunction

    function automatic void model_edge();
        bit sync_lvl;
        if (R) begin
            model_reset();
            return;
        end
        case (m_state)
            0: if (m_press) begin m_mode = int'(sel); m_state = 1; end
            1: begin
                if (tick && exp_terminal()) m_state = 3;
                else if (m_press)           m_state = 2;
            end
            2: if (m_press) m_state = 1;
            default: ;
        endcase
        // Synchronized level is the P sample taken two edges ago.
        sync_lvl = p_hist[1];
        m_press  = 0;
        if (sync_lvl != m_db) begin
            m_run++;
            if (m_run == DB) begin
                m_db    = sync_lvl;
                m_run   = 0;
                m_press = m_db;
            end
        end else begin
            m_run = 0;
        end
        p_hist.push_front(bit'(P));
        p_hist = p_hist[0:1];
    endfunction

    task automatic check_outputs();
        check_eq("cstate",    16'(cstate),    16'(m_state));
        check_eq("cnt_en",    16'(cnt_en),    16'((m_state == 1) && tick && !exp_terminal()));
        check_eq("ld_strobe", 16'(ld_strobe), 16'(m_state == 0));
        check_eq("cnt_dir",   16'(cnt_dir),   16'(exp_dir()));
        check_eq("ld_val",    ld_val,         exp_ld_val());
    endtask

    // One clock cycle: apply staged inputs, check outputs, then advance the model at the edge.
    task automatic step();
        @(negedge clk);
        R = d_R; tick = d_tick; P = d_P; sel = d_sel; load = d_load;
        cnt_max = d_max; cnt_zero = d_zero;
        if (d_R) model_reset();
        #3;
        check_outputs();
        @(posedge clk);
        model_edge();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Hold P high until the press pulse is live in the current cycle.
    task automatic arm_press();
        d_P = 1'b1;
        steps(DB + 2);
    endtask

    task automatic release_button();
        d_P = 1'b0; d_tick = 1'b0;
        steps(DB + 4);
    endtask

    task automatic do_reset();
        d_R = 1'b1; d_tick = 1'b0; d_P = 1'b0; d_max = 1'b0; d_zero = 1'b0;
        steps(2);
        d_R = 1'b0;
        step();
    endtask

    int hold;

    initial begin
        model_reset();
        R = 1'b1; tick = 1'b0; P = 1'b0; sel = 2'b01; load = 8'h25;
        cnt_max = 1'b0; cnt_zero = 1'b0;
        d_R = 1'b1; d_tick = 1'b0; d_P = 1'b0; d_sel = 2'b01; d_load = 8'h25;
        d_max = 1'b0; d_zero = 1'b0;

        // Reset state with live sel=01, load=25.
        steps(2);
        #1;
        check_eq("rst_cstate",    16'(cstate),    16'h0);
        check_eq("rst_ld_strobe", 16'(ld_strobe), 16'h1);
        check_eq("rst_ld_val",    ld_val,         16'h2500);
        check_eq("rst_cnt_dir",   16'(cnt_dir),   16'h1);
        d_R = 1'b0;
        step();

        // Short 3-cycle bounce: no press.
        d_P = 1'b1;
        steps(3);
        d_P = 1'b0;
        steps(DB + 4);
        #1;
        check_eq("short_p_idle", 16'(cstate), 16'h0);

        // Clean press: cstate changes exactly DB+3 edges after first sample.
        d_P = 1'b1;
        steps(DB + 2);
        #1;
        check_eq("lat_before", 16'(cstate), 16'h0);
        step();
        #1;
        check_eq("lat_at", 16'(cstate), 16'h1);
        steps(10 - (DB + 3));
        d_P = 1'b0; d_tick = 1'b1; d_max = 1'b0;
        step();
        #1;
        check_eq("run_tick_en", 16'(cnt_en), 16'h1);
        steps(3);
        release_button();

        // Mode 10: press -> pause, ticks ignored, sel change ignored, press -> run.
        do_reset();
        d_sel = 2'b10;
        arm_press();
        step();
        release_button();
        arm_press();
        step();
        #1;
        check_eq("pause_state", 16'(cstate), 16'h2);
        d_P = 1'b0; d_tick = 1'b1;
        step();
        #1;
        check_eq("pause_no_en", 16'(cnt_en), 16'h0);
        d_tick = 1'b0;
        release_button();
        d_sel = 2'b00;
        arm_press();
        step();
        #1;
        check_eq("resume_state", 16'(cstate), 16'h1);
        check_eq("resume_dir",   16'(cnt_dir), 16'h0);
        release_button();

        // Terminal tick with concurrent press: DONE wins, no count.
        arm_press();
        d_tick = 1'b1; d_zero = 1'b1;
        @(negedge clk);
        R = d_R; tick = d_tick; P = d_P; sel = d_sel; load = d_load;
        cnt_max = d_max; cnt_zero = d_zero;
        #3;
        check_eq("done_no_en", 16'(cnt_en), 16'h0);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("done_state", 16'(cstate), 16'h3);
        d_zero = 1'b0;
        release_button();
        arm_press();
        step();
        release_button();
        #1;
        check_eq("done_sticky", 16'(cstate), 16'h3);

        // Async reset mid-RUN, between edges.
        do_reset();
        d_sel = 2'b01; d_load = 8'h3f;
        arm_press();
        step();
        d_P = 1'b0; d_tick = 1'b1; d_max = 1'b0;
        step();
        @(negedge clk);
        #2;
        R = 1'b1;
        model_reset();
        #1;
        check_eq("arst_cstate",    16'(cstate),    16'h0);
        check_eq("arst_cnt_en",    16'(cnt_en),    16'h0);
        check_eq("arst_ld_strobe", 16'(ld_strobe), 16'h1);
        check_eq("arst_ld_val",    ld_val,         16'h3900);
        d_R = 1'b1; d_tick = 1'b0;
        step();
        d_R = 1'b0;
        steps(2);

        // Randomized traffic.
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                d_P  = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 9);
            end
            hold--;
            d_tick = 1'($urandom_range(0, 1));
            d_max  = ($urandom_range(0, 5) == 0);
            d_zero = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) == 0) d_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) d_load = 8'($urandom_range(0, 255));
            d_R = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
